dmem_responder: RTL

//  Responder end of the data-memory port driven by the core's MEM stage: accepts one load/store

---
 rtl/dmem_responder_pkg.sv | 62 ++++++
 rtl/dmem_responder_load_extend.sv | 29 ++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// responder FSM states and small helpers for request checking and
// byte-lane store merging.
package dmem_responder_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    // Stores only know B/H/W; loads additionally know BU/HU.
    function automatic logic functIllegal(input logic write, input logic [2:0] funct);
        logic bad;
        if (write) begin
            bad = (funct > F3_W);
        end else begin
            bad = (funct == 3'b011) || (funct == 3'b110) || (funct == 3'b111);
        end
        return bad;
    endfunction

    // Access size comes from funct[1:0]; halves need an even lane,
    // words need lane 0.
    function automatic logic misaligned(input logic [2:0] funct, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (funct[1:0])
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Merges right-justified store data into the old word at the given
    // lane; lanes outside the access keep their previous contents.
    function automatic logic [WORD_W-1:0] storeMerge(input logic [WORD_W-1:0] oldWord,
                                                     input logic [WORD_W-1:0] wdata,
                                                     input logic [1:0]        lane,
                                                     input logic [2:0]        funct);
        logic [WORD_W-1:0] mask;
        logic [WORD_W-1:0] data;
        case (funct[1:0])
            2'b00:   begin mask = 32'h0000_00FF; data = wdata & 32'h0000_00FF; end
            2'b01:   begin mask = 32'h0000_FFFF; data = wdata & 32'h0000_FFFF; end
            default: begin mask = 32'hFFFF_FFFF; data = wdata;                 end
        endcase
        mask = mask << {lane, 3'b000};
        data = data << {lane, 3'b000};
        return (oldWord & ~mask) | data;
    endfunction

endpackage

// File: rtl/dmem_responder_load_extend.sv
// Load result formatting: moves the addressed lane down to bit 0 and
// applies sign or zero extension according to the load funct3.
module load_extend
    import dmem_responder_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        lane,
    input  logic [2:0]        funct,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] shifted;

    assign shifted = word >> {lane, 3'b000};

    // Select width and extension of the right-justified lane data.
    always_comb begin
        rdata = '0;
        case (funct)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata = shifted;
            F3_BU:   rdata = {24'h0, shifted[7:0]};
            F3_HU:   rdata = {16'h0, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage. Takes one load/store at a time,
// waits a fixed number of cycles, then commits the store or captures the
// load and presents the response until the consumer takes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    stateT             state;
    logic [3:0]        waitCount;
    logic              latWrite;
    logic [2:0]        latFunct;
    logic [ADDR_W-1:0] latAddr;
    logic [WORD_W-1:0] latWdata;

    logic [WORD_W-1:0] mem [0:DEPTH-1];

    logic              accept;
    logic              commitNow;
    logic              curWrite;
    logic [2:0]        curFunct;
    logic [ADDR_W-1:0] curAddr;
    logic [WORD_W-1:0] curWdata;
    logic [1:0]        curLane;
    logic [IDX_W-1:0]  curIdx;
    logic [MEM_AW-1:0] memIdx;
    logic              rangeErr;
    logic              curErr;
    logic [WORD_W-1:0] oldWord;
    logic [WORD_W-1:0] loadData;
    logic [WORD_W-1:0] rspDataNext;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // With zero wait cycles the commit edge is the accept edge, so the
    // request is taken straight from the ports; otherwise from the latches.
    assign curWrite = (state == IDLE) ? req_write : latWrite;
    assign curFunct = (state == IDLE) ? req_funct : latFunct;
    assign curAddr  = (state == IDLE) ? req_addr  : latAddr;
    assign curWdata = (state == IDLE) ? req_wdata : latWdata;

    assign curLane  = curAddr[1:0];
    assign curIdx   = curAddr[ADDR_W-1:2];
    assign memIdx   = curIdx[MEM_AW-1:0];
    assign rangeErr = (32'(curIdx) >= 32'(DEPTH));
    assign curErr   = functIllegal(curWrite, curFunct) | misaligned(curFunct, curLane) | rangeErr;

    assign commitNow = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (waitCount == 4'd0));

    assign oldWord = mem[memIdx];

    load_extend u_loadExtend (
        .word  (oldWord),
        .lane  (curLane),
        .funct (curFunct),
        .rdata (loadData)
    );

    assign rspDataNext = (curWrite || curErr) ? '0 : loadData;

    // Array write with read-modify-write merge on the edge that enters RESP;
    // faulty requests never touch the array.
    always_ff @(posedge clk) begin
        if (commitNow && curWrite && !curErr && !reset) begin
            mem[memIdx] <= storeMerge(oldWord, curWdata, curLane, curFunct);
        end
    end

    // Request/wait/response sequencing with registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            waitCount <= 4'd0;
            latWrite  <= 1'b0;
            latFunct  <= 3'd0;
            latAddr   <= '0;
            latWdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        latWrite <= req_write;
                        latFunct <= req_funct;
                        latAddr  <= req_addr;
                        latWdata <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rspDataNext;
                            rsp_err   <= curErr;
                        end else begin
                            state     <= WAIT;
                            waitCount <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (waitCount == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rspDataNext;
                        rsp_err   <= curErr;
                    end else begin
                        waitCount <= waitCount - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
